dense_neuron: RTL and testbench
===============================

Name: dense_neuron

Overview:
- Single-output fully-connected (dense) neuron that sits directly upstream of the final classification threshold stage.
- Consumes a stream of N_INPUTS signed Q8.8 features and multiply-accumulates each against a locally stored Q8.8 weight.
- Adds a Q8.8 bias, rescales and saturates the result to signed 16-bit Q8.8, then emits it with a one-cycle valid pulse.
- out_data/valid_out connect directly to the threshold stage's in_data/valid_in.

Parameters:
- N_INPUTS, 16: number of features per frame (2..256).
- FRAC, 8: fractional bits of the Q format used for inputs, weights, bias and output.
- ACC_W, 40: accumulator width. Must be at least 32 + clog2(N_INPUTS) + 1.
- BIAS, 16'sd0: signed Q8.8 bias added once per frame.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  feature present on in_data
- in_ready  out  1  block can accept a feature this cycle
- in_data  in  16  signed Q8.8 feature
- w_we  in  1  weight write strobe
- w_addr  in  clog2(N_INPUTS)  weight index
- w_data  in  16  signed Q8.8 weight
- valid_out  out  1  one-cycle pulse; out_data is valid
- out_data  out  16  signed Q8.8 neuron result, registered
- sat  out  1  result was clamped; qualified by valid_out
- busy  out  1  a frame is in progress (state != IDLE)

Behaviour:
- Reset values: valid_out=0, out_data=0, sat=0, busy=0, acc=0, idx=0, state=IDLE. The weight RAM is not cleared by reset.
- Feature accept:
  - A feature is accepted on a rising edge where in_valid && in_ready.
  - in_ready = (state != FINISH), derived combinationally from registered state.
  - Gaps in in_valid are allowed; idx and acc hold across gaps.
- State machine:
  - IDLE: no feature of the current frame accepted yet. On accept: acc <= product, idx <= 1, go to ACCUM. If N_INPUTS==1, go directly to FINISH.
  - ACCUM: on accept: acc <= acc + product, idx <= idx+1. When the accepted feature is index N_INPUTS-1, go to FINISH.
  - FINISH: register the output, pulse valid_out, clear acc and idx, return to IDLE. Lasts exactly one cycle; in_ready=0 during it.
- Arithmetic:
  - product = in_data * weight[idx]: signed 16x16 -> 32 bits (Q16.16), sign-extended to ACC_W.
  - sum = acc + (BIAS sign-extended, shifted left by FRAC).
  - res = sum >>> FRAC (arithmetic shift, floor rounding).
  - If res > 32767: out_data = 16'h7FFF, sat=1. If res < -32768: out_data = 16'h8000, sat=1. Otherwise out_data = res[15:0], sat=0.
- Latency: if the last feature is accepted at edge k, then out_data, sat and valid_out update at edge k+1, and valid_out is high for exactly the cycle k+1..k+2. The first feature of the next frame can be accepted at edge k+2.
- valid_out is low in every other cycle. out_data and sat hold their last values until the next frame completes.
- Weight writes:
  - Accepted only when state==IDLE. Write at edge: weight[w_addr] <= w_data.
  - w_we in ACCUM or FINISH is ignored, so weights stay stable within a frame.
  - w_addr >= N_INPUTS is ignored.
  - w_we together with an in_valid accept in IDLE: the write is dropped, and the accept uses the old weight.
- Reset mid-frame: state returns to IDLE, and acc, idx and outputs are cleared. The partial frame is discarded with no valid_out. Weights are retained.
- Simultaneous valid_out and a new in_valid: not possible because in_ready=0 in FINISH. An upstream source that holds in_valid simply waits one cycle.

Test Plan:
- Basic MAC: N_INPUTS=4, BIAS=0, all weights 0x0100. Stream 0x0100, 0x0200, 0x0300, 0xFF00 back-to-back -> valid_out one cycle after the 4th accept, out_data=0x0500, sat=0, in_ready low that cycle only.
- Bias and fractions: BIAS=16'sh0080, weights 0x0080 (0.5), inputs all 0x0100 with N=4 -> out_data=0x0280. Input 0xFFFF (-1/256) times weight 0x0080 floors to -1 LSB: single input, rest 0, BIAS=0 -> out_data=0xFFFF.
- Saturation: weights 0x7F00, inputs 0x7F00 -> out_data=0x7FFF, sat=1. Inputs 0x8000, weights 0x7F00 -> out_data=0x8000, sat=1.
- Stalls and spacing: random in_valid gaps (0-5 cycles) within a frame -> same result as back-to-back, exactly one valid_out per N accepts. Two consecutive frames -> two pulses separated by at least N+1 cycles.
- Weight write protection: w_we to index 0 with 0x0000 while in ACCUM -> ignored, and the frame result is unchanged. The same write in IDLE takes effect on the next frame.
- Reset mid-frame: assert rst after 2 of 4 features -> no valid_out, busy=0, out_data=0. A following full frame produces the correct result with the old weights intact.

Source files
------------

// File: rtl/dense_neuron.sv
// rtl/dense_neuron.sv - single-output dense neuron: streamed Q8.8 MAC, bias, floor rescale, saturate
// Weights live in a small register file that is writable only between frames.
module dense_neuron #(
  parameter int                 N_INPUTS = 16,
  parameter int                 FRAC     = 8,
  parameter int                 ACC_W    = 40,
  parameter logic signed [15:0] BIAS     = 16'sd0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [15:0]                 in_data,
  input  logic                        w_we,
  input  logic [$clog2(N_INPUTS)-1:0] w_addr,
  input  logic [15:0]                 w_data,
  output logic                        valid_out,
  output logic [15:0]                 out_data,
  output logic                        sat,
  output logic                        busy
);

  localparam int AW = $clog2(N_INPUTS);
  localparam logic signed [ACC_W-1:0] BIAS_SH = $signed(ACC_W'(BIAS)) <<< FRAC;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

  typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [15:0]             weight [N_INPUTS];
  logic [AW-1:0]           idx;
  logic signed [ACC_W-1:0] acc;
  logic signed [31:0]      product;
  logic signed [ACC_W-1:0] product_ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] res;
  logic                    accept;
  logic                    last_feat;
  logic                    addr_ok;
  logic                    w_ok;
  logic                    sat_hi;
  logic                    sat_lo;
  logic [15:0]             res_q;

  assign accept      = in_valid && in_ready;
  assign last_feat   = (idx == AW'(N_INPUTS - 1));
  assign product     = $signed(in_data) * $signed(weight[idx]);
  assign product_ext = ACC_W'(product);

  // Bias is folded in only at FINISH, so acc stays a pure dot product.
  assign sum    = acc + BIAS_SH;
  assign res    = sum >>> FRAC;
  assign sat_hi = (res > SAT_MAX);
  assign sat_lo = (res < SAT_MIN);
  assign res_q  = sat_hi ? 16'h7FFF : (sat_lo ? 16'h8000 : res[15:0]);

  generate
    if ((1 << AW) == N_INPUTS) begin : g_addr_full
      assign addr_ok = 1'b1;
    end else begin : g_addr_chk
      assign addr_ok = (32'(w_addr) < N_INPUTS);
    end
  endgenerate

  // A write colliding with an accept is dropped so the accept sees the old weight.
  assign w_ok = w_we && (state == IDLE) && !accept && addr_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (N_INPUTS == 1) ? FINISH : ACCUM;
        end
      end
      ACCUM: begin
        if (accept && last_feat) begin
          state_nxt = FINISH;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state != FINISH);
    busy     = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      idx       <= '0;
      valid_out <= 1'b0;
      out_data  <= 16'h0000;
      sat       <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            acc <= product_ext;
            idx <= AW'(1);
          end
        end
        ACCUM: begin
          if (accept) begin
            acc <= acc + product_ext;
            idx <= idx + AW'(1);
          end
        end
        FINISH: begin
          valid_out <= 1'b1;
          out_data  <= res_q;
          sat       <= sat_hi || sat_lo;
          acc       <= '0;
          idx       <= '0;
        end
        default: begin
          acc <= '0;
          idx <= '0;
        end
      endcase
    end
  end

  // Weight storage survives reset by design.
  always_ff @(posedge clk) begin
    if (w_ok) begin
      weight[w_addr] <= w_data;
    end
  end

endmodule

// File: tb/tb_dense_neuron.sv
// tb/tb_dense_neuron.sv - directed bench for dense_neuron, one instance with BIAS=0 and one with BIAS=0.5
module tb_dense_neuron;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        w_we;
  logic [1:0]  w_addr;
  logic [15:0] w_data;
  logic        r0, r1, v0, v1, s0, s1, b0, b1;
  logic [15:0] o0, o1;
  int          vec = 0;
  int          miscompares = 0;
  int          pulses = 0;
  int          p_before;
  time         last_t = 0;
  time         prev_t = 0;

  always #5 clk = ~clk;

  dense_neuron #(.N_INPUTS(4), .FRAC(8), .ACC_W(40), .BIAS(16'sh0000)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r0), .in_data(in_data),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .valid_out(v0), .out_data(o0), .sat(s0), .busy(b0)
  );

  dense_neuron #(.N_INPUTS(4), .FRAC(8), .ACC_W(40), .BIAS(16'sh0080)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r1), .in_data(in_data),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .valid_out(v1), .out_data(o1), .sat(s1), .busy(b1)
  );

  always @(negedge clk) begin
    if (v0) begin
      pulses++;
      prev_t = last_t;
      last_t = $time;
    end
  end

  task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vec++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    vec++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    vec++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    w_we = 1'b1; w_addr = a; w_data = d;
    @(posedge clk); #1;
    w_we = 1'b0;
  endtask

  task automatic wr_all(input logic [15:0] d);
    for (int i = 0; i < 4; i++) wr(2'(i), d);
  endtask

  // Presents one feature (optionally with a write to weight 0) until it is accepted.
  task automatic send(input logic [15:0] d, input logic we, input logic [15:0] wd);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d;
    w_we = we; w_addr = 2'd0; w_data = wd;
    while (!r0 && t < 10) begin
      @(negedge clk);
      t++;
    end
    if (t >= 10) checki("ready_wait", t, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    w_we = 1'b0;
  endtask

  task automatic frame(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c, input logic [15:0] d);
    send(a, 1'b0, 16'h0); send(b, 1'b0, 16'h0);
    send(c, 1'b0, 16'h0); send(d, 1'b0, 16'h0);
  endtask

  // lat > 0: also checks the negedge count to valid_out and in_ready low in the FINISH cycle.
  task automatic wait_out(input string tag, input logic [15:0] e0, input logic es0,
                          input logic [15:0] e1, input logic es1, input int lat);
    int   n;
    logic rdy1;
    n = 0;
    rdy1 = 1'bx;
    while (!v0 && n < 20) begin
      @(negedge clk);
      n++;
      if (n == 1) rdy1 = r0;
    end
    check1({tag, "_valid"}, v0, 1'b1);
    check1({tag, "_valid_b"}, v1, 1'b1);
    check16({tag, "_out0"}, o0, e0);
    check1({tag, "_sat0"}, s0, es0);
    check16({tag, "_out1"}, o1, e1);
    check1({tag, "_sat1"}, s1, es1);
    if (lat > 0) begin
      checki({tag, "_latency"}, n, lat);
      check1({tag, "_ready_finish"}, rdy1, 1'b0);
    end
    @(negedge clk);
    check1({tag, "_pulse_end"}, v0, 1'b0);
    check1({tag, "_ready_back"}, r0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 16'h0;
    w_we = 1'b0; w_addr = 2'd0; w_data = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check1("rst_valid", v0, 1'b0);
    check16("rst_out", o0, 16'h0000);
    check1("rst_sat", s0, 1'b0);
    check1("rst_busy", b0, 1'b0);
    check1("rst_ready", r0, 1'b1);
    check16("rst_out_b", o1, 16'h0000);

    // Unit weights: 1 + 2 + 3 - 1 = 5.0
    wr_all(16'h0100);
    frame(16'h0100, 16'h0200, 16'h0300, 16'hFF00);
    wait_out("basic", 16'h0500, 1'b0, 16'h0580, 1'b0, 2);

    // 0.5 weights: 4 * 0.5 = 2.0
    wr_all(16'h0080);
    frame(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    wait_out("half", 16'h0200, 1'b0, 16'h0280, 1'b0, 2);

    // -1/256 * 0.5 floors to -1 LSB
    frame(16'hFFFF, 16'h0000, 16'h0000, 16'h0000);
    wait_out("floor", 16'hFFFF, 1'b0, 16'h007F, 1'b0, 2);

    wr_all(16'h7F00);
    frame(16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00);
    wait_out("sat_pos", 16'h7FFF, 1'b1, 16'h7FFF, 1'b1, 2);
    frame(16'h8000, 16'h8000, 16'h8000, 16'h8000);
    wait_out("sat_neg", 16'h8000, 1'b1, 16'h8000, 1'b1, 2);

    // Random gaps between features
    wr_all(16'h0100);
    p_before = pulses;
    repeat ($urandom_range(0, 5)) @(negedge clk);
    send(16'h0100, 1'b0, 16'h0);
    repeat ($urandom_range(0, 5)) @(negedge clk);
    send(16'h0200, 1'b0, 16'h0);
    repeat ($urandom_range(0, 5)) @(negedge clk);
    send(16'h0300, 1'b0, 16'h0);
    repeat ($urandom_range(0, 5)) @(negedge clk);
    send(16'hFF00, 1'b0, 16'h0);
    wait_out("stall", 16'h0500, 1'b0, 16'h0580, 1'b0, 2);
    checki("stall_pulses", pulses - p_before, 1);

    // Two frames with no idle gap between them
    p_before = pulses;
    frame(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    frame(16'h0200, 16'h0200, 16'h0200, 16'h0200);
    wait_out("b2b", 16'h0800, 1'b0, 16'h0880, 1'b0, 2);
    checki("b2b_pulses", pulses - p_before, 2);
    check1("b2b_spacing", (last_t - prev_t) >= 50, 1'b1);

    // Writes during ACCUM are ignored
    send(16'h0100, 1'b0, 16'h0);
    send(16'h0200, 1'b1, 16'h0000);
    send(16'h0300, 1'b1, 16'h0000);
    send(16'hFF00, 1'b0, 16'h0);
    wait_out("wprot", 16'h0500, 1'b0, 16'h0580, 1'b0, 2);
    wr(2'd0, 16'h0000);
    frame(16'h0100, 16'h0200, 16'h0300, 16'hFF00);
    wait_out("widle", 16'h0400, 1'b0, 16'h0480, 1'b0, 2);

    // Write alongside the first accept is dropped; accept sees old weight 0
    send(16'h0100, 1'b1, 16'h0100);
    send(16'h0200, 1'b0, 16'h0);
    send(16'h0300, 1'b0, 16'h0);
    send(16'hFF00, 1'b0, 16'h0);
    wait_out("wcoll", 16'h0400, 1'b0, 16'h0480, 1'b0, 2);
    frame(16'h0100, 16'h0200, 16'h0300, 16'hFF00);
    wait_out("wcoll_after", 16'h0400, 1'b0, 16'h0480, 1'b0, 2);

    // Reset after two of four features
    wr(2'd0, 16'h0100);
    send(16'h0100, 1'b0, 16'h0);
    send(16'h0200, 1'b0, 16'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    p_before = pulses;
    @(negedge clk);
    check1("mrst_busy", b0, 1'b0);
    check16("mrst_out", o0, 16'h0000);
    check1("mrst_sat", s0, 1'b0);
    check1("mrst_valid", v0, 1'b0);
    check16("mrst_out_b", o1, 16'h0000);
    check1("mrst_busy_b", b1, 1'b0);
    check1("mrst_ready_b", r1, 1'b1);
    repeat (6) @(negedge clk);
    checki("mrst_no_pulse", pulses - p_before, 0);
    frame(16'h0100, 16'h0200, 16'h0300, 16'hFF00);
    wait_out("post_rst", 16'h0500, 1'b0, 16'h0580, 1'b0, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
    $finish;
  end
endmodule
